// File: rtl/fifo_wr_arb.sv
// Round-robin write-side arbiter: NUM_REQ byte producers share one FIFO write port, grant held per frame.
// Optional stall counter port enabled by macro FIFO_WR_ARB_STALL_CNT_EN.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            gnt
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]   sel_idx, idx_inc;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               sel_found;
  logic               xfer;
  int unsigned        cand;

  // First valid requester at or above rr_ptr, wrapping
  always_comb begin
    sel_idx   = rr_ptr;
    sel_found = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr) + i) % NUM_REQ;
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  assign idx_inc = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign busy    = (state == BUSY);
  assign xfer    = (state == BUSY) && req_valid[gnt_idx] && !wfull;

  always_comb begin
    req_ready = '0;
    winc      = xfer;
    wr_data   = '0;
    if (xfer) begin
      req_ready[gnt_idx] = 1'b1;
      wr_data            = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    gnt_nxt     = gnt;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt            = BUSY;
          gnt_idx_nxt          = sel_idx;
          gnt_nxt              = '0;
          gnt_nxt[sel_idx]     = 1'b1;
        end
      end
      BUSY: begin
        if (xfer && req_last[gnt_idx]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = idx_inc;
          gnt_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      gnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      gnt     <= gnt_nxt;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt <= '0;
    end else if ((state == BUSY) && req_valid[gnt_idx] && wfull && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
